imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot loader for the instruction memory: the write side of the CPU's read-only instruction-fetch path.
//  Consumes a framed byte stream (valid/ready), assembles little-endian 32-bit words and writes them
//  to consecutive instruction-memory word slots. Holds the core in reset until a frame loads and verifies.
//  Sits beside riscv; cpu_rst_o drives the core's rst_i, and the mem_* outputs drive the imem write port.
// PARAMETERS
//  ADDR_WIDTH  32     byte-address width of mem_addr_o
//  MEM_WORDS   1024   instruction-memory capacity in 32-bit words; maximum legal frame length
//  BASE_ADDR   32'h0  byte address of the first loaded word
// PORTS
//  clk_i            in   1            clock; the only clock; all logic on the rising edge
//  rst_i            in   1            synchronous, active-high reset
//  start_i          in   1            begin a new load; honoured in IDLE, DONE and ERROR only
//  byte_i           in   8            stream byte
//  byte_valid_i     in   1            byte_i is valid
//  byte_ready_o     out  1            loader accepts; a transfer happens when byte_valid_i & byte_ready_o
//  mem_we_o         out  1            single-cycle instruction-memory write strobe
//  mem_addr_o       out  ADDR_WIDTH   write byte address, always word-aligned
//  mem_wdata_o      out  32           write data
//  cpu_rst_o        out  1            core reset; low only in DONE
//  busy_o           out  1            high in LEN, DATA or CSUM
//  done_o           out  1            high in DONE
//  error_o          out  1            high in ERROR
//  words_loaded_o   out  $clog2(MEM_WORDS+1)  number of words written in the current frame
// BEHAVIOUR
//  Frame format: 4-byte little-endian length N (in words), then 4*N payload bytes (little-endian words),
//   then 1 checksum byte equal to the XOR of all payload bytes.
//  Reset values: state IDLE; byte_ready_o=0; mem_we_o=0; mem_addr_o=BASE_ADDR; mem_wdata_o=0;
//   cpu_rst_o=1; busy_o/done_o/error_o=0; words_loaded_o=0; checksum accumulator=0; byte index=0.
//  States and transitions:
//   IDLE  -> LEN on start_i.
//   LEN   -> on the 4th accepted byte: ERROR if N > MEM_WORDS; CSUM if N = 0; otherwise DATA.
//   DATA  -> CSUM when the 4th byte of word N-1 is accepted.
//   CSUM  -> DONE if byte_i equals the accumulator; otherwise ERROR.
//   DONE  -> LEN on start_i.
//   ERROR -> LEN on start_i.
//  Entry to LEN clears the word count, the byte index, the checksum accumulator and words_loaded_o.
//  byte_ready_o is a registered level: 1 in LEN, DATA and CSUM, 0 otherwise. It has no combinational
//   dependence on byte_valid_i. One byte can be accepted per cycle, back to back.
//  Write timing: if the 4th byte of word i is accepted in cycle k, then in cycle k+1:
//   mem_we_o=1, mem_addr_o = BASE_ADDR + 4*i, mem_wdata_o = {b3,b2,b1,b0}, words_loaded_o = i+1.
//   mem_we_o is low in every other cycle. The checksum byte may be accepted in that same cycle k+1.
//  Arithmetic and width rules:
//   Address arithmetic is modulo 2^ADDR_WIDTH.
//   The length comparison uses all 32 bits of N; upper bits are not truncated.
//  start_i in LEN, DATA or CSUM is ignored.
//  Bytes presented while byte_ready_o=0 are not consumed.
//  ERROR and DONE are sticky until start_i or rst_i. cpu_rst_o stays 1 in ERROR.
//  Words already written are not rolled back on ERROR or on reset.
//  rst_i mid-frame: next cycle is in IDLE with all reset values; any pending write strobe is suppressed.
// STRUCTURE
//  Package imem_loader_pkg holds:
//   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} loader_state_t;
//   localparam LEN_BYTES = 4 and localparam WORD_BYTES = 4.
//  Sub-module word_assembler: shifts in bytes under an accept strobe and raises word_valid with the
//   assembled word; it is reused for the length field and for payload words.
//  The FSM, counters and checksum logic live in imem_loader.
// TESTING
//  1 Frame 02 00 00 00 | 13 05 10 00 | 93 00 20 00 | B5
//     -> writes (0x0, 0x00100513) then (0x4, 0x00200093); done_o=1, cpu_rst_o=0, words_loaded_o=2.
//  2 Same frame with checksum byte B4
//     -> both writes occur; error_o=1, cpu_rst_o=1; start_i then a valid frame -> done_o=1.
//  3 Length 01 04 00 00 (1025 words) with MEM_WORDS=1024
//     -> error_o=1 one cycle after the 4th byte; no mem_we_o; later bytes are not accepted.
//  4 Frame 1 with byte_valid_i driven randomly at 50%, plus bytes presented in IDLE
//     -> same writes as test 1; IDLE bytes not consumed (byte_ready_o=0).
//  5 rst_i for one cycle after the 5th payload byte of frame 1
//     -> IDLE next cycle, no write of word 1, words_loaded_o=0; a full reload then reaches DONE.
//  6 Frame 00 00 00 00 | 00
//     -> no mem_we_o; done_o=1, words_loaded_o=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

    // Bytes in the little-endian length header.
    localparam int LEN_BYTES  = 4;
    // Bytes per instruction word.
    localparam int WORD_BYTES = 4;

    // States in which the loader takes bytes from the stream.
    function automatic logic is_rx_state(loader_state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

    // States in which start_i opens a new frame.
    function automatic logic is_start_state(loader_state_t s);
        return (s == IDLE) || (s == DONE) || (s == ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian word assembler: shifts bytes in under an accept strobe and
// presents the completed 32-bit word in the same cycle its last byte is
// accepted. Used for both the length header and the payload words.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    // Holds the first three bytes of the word; the oldest byte ends up lowest.
    logic [23:0] shift_q;
    logic [1:0]  idx_q;

    // Shift register and byte index; clear restarts the word at byte 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            shift_q <= {data_byte, shift_q[23:8]};
            idx_q   <= idx_q + 2'd1;
        end
    end

    // The word completes combinationally so the caller can act on it in the
    // cycle the final byte is accepted.
    always_comb begin
        word_valid = accept && (idx_q == 2'(WORD_BYTES - 1));
        word       = {data_byte, shift_q};
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory. Receives a framed byte stream
// (length, payload words, XOR checksum), writes the payload to consecutive
// word slots and releases the core from reset only after the frame verifies.
//
// Stream handshake: a byte moves when byte_valid_i and byte_ready_o are both
// high at a rising edge. byte_ready_o is a registered level that depends only
// on the loader state, never on byte_valid_i; the sender may hold byte_valid_i
// and byte_i stable or change them freely while byte_ready_o is low.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [7:0]                         byte_i,
    input  logic                               byte_valid_i,
    output logic                               byte_ready_o,
    output logic                               mem_we_o,
    output logic [ADDR_WIDTH-1:0]              mem_addr_o,
    output logic [31:0]                        mem_wdata_o,
    output logic                               cpu_rst_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               error_o,
    output logic [$clog2(MEM_WORDS+1)-1:0]     words_loaded_o
);

    localparam int WCW = $clog2(MEM_WORDS + 1);

    loader_state_t state_q;
    loader_state_t state_d;

    logic           accept;
    logic           asm_accept;
    logic           start_load;
    logic           word_valid;
    logic [31:0]    word;
    logic           write_fire;
    logic           last_word;

    logic [WCW-1:0] len_q;
    logic [WCW-1:0] last_idx;
    logic [WCW-1:0] word_idx_q;
    logic [7:0]     csum_q;

    // Handshake qualification and frame-start detection.
    always_comb begin
        accept     = byte_valid_i && byte_ready_o;
        asm_accept = accept && ((state_q == LEN) || (state_q == DATA));
        start_load = start_i && is_start_state(state_q);
        last_idx   = len_q - WCW'(1);
        last_word  = (word_idx_q == last_idx);
        write_fire = (state_q == DATA) && word_valid;
    end

    word_assembler u_word_assembler (
        .clk        (clk_i),
        .rst        (rst_i),
        .clear      (start_load),
        .accept     (asm_accept),
        .data_byte  (byte_i),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The length check uses the full 32-bit header so an
    // oversized frame cannot alias to a small legal length.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LEN;
            end
            LEN: begin
                if (word_valid) begin
                    if (word > 32'(MEM_WORDS)) begin
                        state_d = ERROR;
                    end else if (word == 32'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) state_d = CSUM;
            end
            CSUM: begin
                if (accept) state_d = (byte_i == csum_q) ? DONE : ERROR;
            end
            DONE: begin
                if (start_i) state_d = LEN;
            end
            ERROR: begin
                if (start_i) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status levels are registered from the next state so they change
    // together with the state and carry no path from the stream inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            cpu_rst_o    <= 1'b1;
        end else begin
            byte_ready_o <= is_rx_state(state_d);
            busy_o       <= is_rx_state(state_d);
            done_o       <= (state_d == DONE);
            error_o      <= (state_d == ERROR);
            cpu_rst_o    <= (state_d != DONE);
        end
    end

    // Frame length, word index and payload checksum; all restart on a new frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
        end else if (start_load) begin
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
        end else begin
            if ((state_q == LEN) && word_valid) begin
                // Only kept when the header passed the range check, so the
                // truncation to WCW bits is lossless where it matters.
                len_q <= word[WCW-1:0];
            end
            if ((state_q == DATA) && accept) begin
                csum_q <= csum_q ^ byte_i;
            end
            if (write_fire) begin
                word_idx_q <= word_idx_q + WCW'(1);
            end
        end
    end

    // Memory write port: one-cycle strobe in the cycle after a payload word
    // completes. Reset drops any strobe that would otherwise follow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_we_o       <= 1'b0;
            mem_addr_o     <= BASE_ADDR;
            mem_wdata_o    <= '0;
            words_loaded_o <= '0;
        end else begin
            mem_we_o <= write_fire;
            if (write_fire) begin
                mem_addr_o     <= BASE_ADDR + (ADDR_WIDTH'(word_idx_q) << 2);
                mem_wdata_o    <= word;
                words_loaded_o <= word_idx_q + WCW'(1);
            end else if (start_load) begin
                words_loaded_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: drives framed byte streams and checks the write
// port against a queue of expected (address, data, words_loaded) triples.
module tb_imem_loader;

    localparam int AW  = 32;
    localparam int MW  = 1024;
    localparam int WCW = $clog2(MW + 1);
    localparam int EW  = 32 + 32 + WCW;
    localparam logic [31:0] BASE = 32'h0;

    logic           clk;
    logic           rst;
    logic           start;
    logic [7:0]     byte_in;
    logic           byte_valid;
    logic           byte_ready;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic           cpu_rst;
    logic           busy;
    logic           done;
    logic           error;
    logic [WCW-1:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;

    logic [EW-1:0]  exp_q[$];
    logic [31:0]    payload[0:MW-1];

    imem_loader #(
        .ADDR_WIDTH (AW),
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .byte_i         (byte_in),
        .byte_valid_i   (byte_valid),
        .byte_ready_o   (byte_ready),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .cpu_rst_o      (cpu_rst),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .words_loaded_o (words_loaded)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every write strobe must match the head of exp_q.
    always @(negedge clk) begin
        if (mem_we !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_write: got we=%b addr=%h data=%h, required no write",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata, words_loaded} !== e) begin
                    n_errors++;
                    $display("FAIL write: got addr=%h data=%h wl=%0d, required addr=%h data=%h wl=%0d",
                             mem_addr, mem_wdata, words_loaded,
                             e[EW-1 -: 32], e[EW-33 -: 32], e[WCW-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) begin
            for (int g = 0; g < 6 && $urandom_range(0, 1) == 1; g++) begin
                byte_valid = 1'b0;
                byte_in    = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        byte_in    = b;
        byte_valid = 1'b1;
        guard      = 0;
        while (byte_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: got byte_ready=%b, required 1 within 50 cycles", byte_ready);
            byte_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gaps);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    // Sends a whole frame from payload[0..nw-1], queueing the expected writes.
    // csum_flip is XORed into the correct checksum to corrupt it on demand.
    task automatic load_frame(input int nw, input logic [7:0] csum_flip, input bit gaps);
        logic [7:0] cs;
        cs = 8'h00;
        send_word(32'(nw), gaps);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({BASE + 32'(4 * i), payload[i], WCW'(i + 1)});
            cs = cs ^ payload[i][7:0] ^ payload[i][15:8] ^ payload[i][23:16] ^ payload[i][31:24];
            send_word(payload[i], gaps);
        end
        send_byte(cs ^ csum_flip, gaps);
    endtask

    task automatic set_frame1();
        payload[0] = 32'h0010_0513;
        payload[1] = 32'h0020_0093;
    endtask

    // Tests
    task automatic test_reset();
        apply_reset(3);
        n_checks++;
        if ({byte_ready, mem_we, cpu_rst, busy, done, error} !== 6'b001000) begin
            n_errors++;
            $display("FAIL reset_flags: got ready,we,cpu_rst,busy,done,error=%b, required 001000",
                     {byte_ready, mem_we, cpu_rst, busy, done, error});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, words_loaded} !== {BASE, 32'h0, WCW'(0)}) begin
            n_errors++;
            $display("FAIL reset_regs: got addr=%h data=%h wl=%0d, required %h 0 0",
                     mem_addr, mem_wdata, words_loaded, BASE);
        end
    endtask

    task automatic test_idle_bytes();
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (byte_ready !== 1'b0 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_not_ready: got ready=%b busy=%b, required 0 0", byte_ready, busy);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_frame(input bit gaps);
        set_frame1();
        pulse_start();
        n_checks++;
        if (byte_ready !== 1'b1 || busy !== 1'b1 || words_loaded !== WCW'(0)) begin
            n_errors++;
            $display("FAIL len_entry: got ready=%b busy=%b wl=%0d, required 1 1 0", byte_ready, busy, words_loaded);
        end
        load_frame(2, 8'h00, gaps);
        n_checks++;
        if ({done, error, busy, cpu_rst, byte_ready} !== 5'b10000 || words_loaded !== WCW'(2)) begin
            n_errors++;
            $display("FAIL frame_done: got done,err,busy,cpu_rst,ready=%b wl=%0d, required 10000 wl=2",
                     {done, error, busy, cpu_rst, byte_ready}, words_loaded);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL frame_writes: got %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        set_frame1();
        pulse_start();
        load_frame(2, 8'h01, 1'b0);
        n_checks++;
        if ({error, done, cpu_rst, busy} !== 4'b1010 || words_loaded !== WCW'(2) || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL bad_csum: got err,done,cpu_rst,busy=%b wl=%0d pending=%0d, required 1010 wl=2 pending=0",
                     {error, done, cpu_rst, busy}, words_loaded, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1) begin
            n_errors++;
            $display("FAIL error_sticky: got err=%b cpu_rst=%b, required 1 1", error, cpu_rst);
        end
        pulse_start();
        load_frame(2, 8'h00, 1'b0);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin
            n_errors++;
            $display("FAIL recover_done: got done=%b err=%b cpu_rst=%b, required 1 0 0", done, error, cpu_rst);
        end
    endtask

    task automatic test_oversize(input logic [31:0] n, input string name);
        pulse_start();
        send_word(n, 1'b0);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: got err=%b busy=%b ready=%b, required 1 0 0", name, error, busy, byte_ready);
        end
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        n_checks++;
        if (byte_ready !== 1'b0 || error !== 1'b1 || words_loaded !== WCW'(0)) begin
            n_errors++;
            $display("FAIL %s_after: got ready=%b err=%b wl=%0d, required 0 1 0", name, byte_ready, error, words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        set_frame1();
        pulse_start();
        send_word(32'd2, 1'b0);
        exp_q.push_back({BASE, payload[0], WCW'(1)});
        send_word(payload[0], 1'b0);
        send_byte(payload[1][7:0], 1'b0);
        apply_reset(1);
        n_checks++;
        if ({byte_ready, mem_we, cpu_rst, busy, done, error} !== 6'b001000 || words_loaded !== WCW'(0)) begin
            n_errors++;
            $display("FAIL reset_mid: got ready,we,cpu_rst,busy,done,err=%b wl=%0d, required 001000 wl=0",
                     {byte_ready, mem_we, cpu_rst, busy, done, error}, words_loaded);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_mid_word0: got %0d writes missing, required 0", exp_q.size());
        end
        pulse_start();
        load_frame(2, 8'h00, 1'b0);
        n_checks++;
        if (done !== 1'b1 || words_loaded !== WCW'(2)) begin
            n_errors++;
            $display("FAIL reload_done: got done=%b wl=%0d, required 1 2", done, words_loaded);
        end
    endtask

    task automatic test_empty();
        pulse_start();
        load_frame(0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || words_loaded !== WCW'(0)) begin
            n_errors++;
            $display("FAIL empty_frame: got done=%b err=%b wl=%0d, required 1 0 0", done, error, words_loaded);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < MW; i++) begin
            payload[i] = $urandom;
        end
        pulse_start();
        load_frame(MW, 8'h00, 1'b0);
        n_checks++;
        if (done !== 1'b1 || words_loaded !== WCW'(MW) || mem_addr !== BASE + 32'(4 * (MW - 1))) begin
            n_errors++;
            $display("FAIL full_frame: got done=%b wl=%0d addr=%h, required 1 %0d %h",
                     done, words_loaded, mem_addr, MW, BASE + 32'(4 * (MW - 1)));
        end
    endtask

    // Sequence and final report
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #1;
        test_reset();
        test_idle_bytes();
        test_frame(1'b1);
        test_frame(1'b0);
        test_bad_csum();
        test_oversize(32'h0000_0401, "oversize_1025");
        test_oversize(32'h0001_0001, "oversize_upper");
        test_reset_mid();
        test_empty();
        test_full();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL final_queue: got %0d writes missing, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
